cordic_iter_core: RTL and testbench
===================================

// Module: cordic_iter_core
// PURPOSE
//  Iterative (one micro-rotation per clock) circular CORDIC engine, Q4.28 fixed point.
//  Sits directly upstream of the correction unit: produces raw, gain-uncompensated X/Y
//  (gain An ~= 1.6467602) plus residual angle Z. The correction stage scales them by K.
//  Supports rotation mode (drive Z to 0) and vectoring mode (drive Y to 0).
// PARAMETERS
//  WIDTH  32  datapath width; Q4.28, range -8 .. 7.99999999627471
//  ITER   16  micro-rotations per operation; legal 1..28
// PORTS
//  clk        in   1      clock; all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand present
//  in_ready   out  1      core can accept; combinational, = (state==IDLE) && !rst
//  mode       in   1      0 = rotation, 1 = vectoring; sampled with operands
//  x_in       in   WIDTH  initial X, Q4.28 two's complement
//  y_in       in   WIDTH  initial Y
//  z_in       in   WIDTH  initial angle, radians Q4.28; rotation mode valid |z| <= ~1.7433
//  out_valid  out  1      result held valid
//  out_ready  in   1      downstream (correction stage) accepts result
//  x_out      out  WIDTH  raw X (times An)
//  y_out      out  WIDTH  raw Y (times An)
//  z_out      out  WIDTH  residual/accumulated angle
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, x_out=y_out=z_out=0, iteration counter=0, busy=0.
//  FSM: IDLE -> RUN on in_valid&&in_ready (load x,y,z,mode; i=0).
//       RUN: one iteration per cycle; after iteration i=ITER-1 -> DONE.
//       DONE: out_valid=1; -> IDLE on out_ready. No accept while in DONE (no bypass).
//  Iteration i: rotation d = (z>=0)?+1:-1; vectoring d = (y<0)?+1:-1.
//       x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_lut[i].
//  Shifts are arithmetic; add/sub wrap mod 2^WIDTH (no saturation, no overflow flag).
//  atan_lut[i] = round(atan(2^-i) * 2^28): [0]=0x0C90FDAA, [1]=0x076B19C1,
//       [2]=0x03EB6EBF, ... ; entries 0..27 are hard-coded constants.
//  Latency: accept at edge E -> out_valid high from edge E+ITER+1; then one result per handshake.
//  Outputs registered; x/y/z_out stable while out_valid=1 and out_ready=0 (any duration).
//  x/y/z_out update only on the DONE transition; they hold the previous result in IDLE/RUN.
//  in_valid ignored outside IDLE; operand changes during RUN have no effect.
//  out_valid && out_ready in DONE: in_ready rises the next cycle (min 1 idle cycle between ops).
//  rst asserted mid-RUN or in DONE: abort, discard result, reset values next edge.
// TESTING  (ITER=16; tolerance |err| <= 0x8000 LSB unless stated)
//  1 Rotation x=0x08000000,y=0,z=0 -> x_out~0x0D2C9082 (0.5*An), y_out~0, z_out~0.
//  2 Rotation x=0x09B74EDA(K),y=0,z=0x0C90FDAA(pi/4) -> x_out~y_out~0x0B504F33.
//  3 Vectoring x=y=0x10000000 -> z_out~0x0C90FDAA, y_out~0, x_out~0x25430D30.
//  4 Latency/backpressure: accept on edge E; out_valid rises at E+17; out_ready=0 for 5 cycles
//    -> outputs constant, in_ready=0 throughout; in_ready=1 one cycle after handshake.
//  5 rst pulse at RUN iteration 7 -> next cycle out_valid=0, outputs 0, in_ready=1; new op correct.
//  6 Negative angle z=0xF36F0256(-pi/4), x=K, y=0 -> x_out~0x0B504F33, y_out~0xF4AFB0CD.

Source files
------------

// File: rtl/cordic_iter_core.sv
// Iterative circular CORDIC, one micro-rotation per clock, Q4.28 fixed point.
// Results are raw (scaled by the CORDIC gain); the downstream stage applies K.
module cordic_iter_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] LAST = 5'(ITER);

    state_t                  state_q;
    logic [4:0]              iter_q;
    logic                    mode_q;
    logic                    out_valid_q;
    logic signed [WIDTH-1:0] x_q, y_q, z_q;
    logic signed [WIDTH-1:0] x_out_q, y_out_q, z_out_q;
    logic signed [WIDTH-1:0] x_d, y_d, z_d;
    logic signed [WIDTH-1:0] x_sh, y_sh, ang;
    logic                    d_pos;

    // round(atan(2^-i) * 2^28)
    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = WIDTH'(32'h0C90FDAA);
            5'd1:    atan_lut = WIDTH'(32'h076B19C1);
            5'd2:    atan_lut = WIDTH'(32'h03EB6EBF);
            5'd3:    atan_lut = WIDTH'(32'h01FD5BAA);
            5'd4:    atan_lut = WIDTH'(32'h00FFAADE);
            5'd5:    atan_lut = WIDTH'(32'h007FF557);
            5'd6:    atan_lut = WIDTH'(32'h003FFEAB);
            5'd7:    atan_lut = WIDTH'(32'h001FFFD5);
            5'd8:    atan_lut = WIDTH'(32'h000FFFFB);
            5'd9:    atan_lut = WIDTH'(32'h0007FFFF);
            5'd10:   atan_lut = WIDTH'(32'h00040000);
            5'd11:   atan_lut = WIDTH'(32'h00020000);
            5'd12:   atan_lut = WIDTH'(32'h00010000);
            5'd13:   atan_lut = WIDTH'(32'h00008000);
            5'd14:   atan_lut = WIDTH'(32'h00004000);
            5'd15:   atan_lut = WIDTH'(32'h00002000);
            5'd16:   atan_lut = WIDTH'(32'h00001000);
            5'd17:   atan_lut = WIDTH'(32'h00000800);
            5'd18:   atan_lut = WIDTH'(32'h00000400);
            5'd19:   atan_lut = WIDTH'(32'h00000200);
            5'd20:   atan_lut = WIDTH'(32'h00000100);
            5'd21:   atan_lut = WIDTH'(32'h00000080);
            5'd22:   atan_lut = WIDTH'(32'h00000040);
            5'd23:   atan_lut = WIDTH'(32'h00000020);
            5'd24:   atan_lut = WIDTH'(32'h00000010);
            5'd25:   atan_lut = WIDTH'(32'h00000008);
            5'd26:   atan_lut = WIDTH'(32'h00000004);
            5'd27:   atan_lut = WIDTH'(32'h00000002);
            default: atan_lut = '0;
        endcase
    endfunction

    always_comb begin
        x_sh  = x_q >>> iter_q;
        y_sh  = y_q >>> iter_q;
        ang   = atan_lut(iter_q);
        d_pos = mode_q ? y_q[WIDTH-1] : ~z_q[WIDTH-1];
        if (d_pos) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - ang;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + ang;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q     <= x_in;
                        y_q     <= y_in;
                        z_q     <= z_in;
                        mode_q  <= mode;
                        iter_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // Extra cycle after the last iteration registers the result
                    if (iter_q == LAST) begin
                        x_out_q     <= x_q;
                        y_out_q     <= y_q;
                        z_out_q     <= z_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        x_q    <= x_d;
                        y_q    <= y_d;
                        z_q    <= z_d;
                        iter_q <= iter_q + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_iter_core.sv
// Directed bench for cordic_iter_core: numeric results, latency, backpressure and reset abort.
module tb_cordic_iter_core;

    localparam int WIDTH = 32;
    localparam int ITER  = 16;
    localparam logic [31:0] K_CONST = 32'h09B74EDA;
    localparam int TOL = 32'h8000;

    logic clk = 1'b0;
    logic rst, in_valid, mode, out_ready;
    logic in_ready, out_valid, busy;
    logic signed [WIDTH-1:0] x_in, y_in, z_in, x_out, y_out, z_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] hold_x, hold_y, hold_z;

    always #5 clk = ~clk;

    cordic_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol);
        int diff;
        checks++;
        diff = $signed(got - exp);
        if (diff > tol || diff < -tol) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (tol 0x%0h)", tag, got, exp, tol);
        end
    endtask

    // Presents one operand set; returns at the negedge right after the accept edge
    task automatic launch(input string tag, input logic m, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] z);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, in_ready, 1, 0);
        in_valid = 1'b1; mode = m; x_in = x; y_in = y; z_in = z;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0;
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, ITER + 1, 0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1, 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_x_out", x_out, 0, 0);
        chk("rst_y_out", y_out, 0, 0);
        chk("rst_z_out", z_out, 0, 0);
        chk("rst_busy", busy, 0, 0);
        chk("rst_in_ready_low", in_ready, 0, 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_high", in_ready, 1, 0);

        // Test 1: rotation of 0.5 by zero angle; junk operands during RUN must be ignored
        launch("t1", 1'b0, 32'h08000000, 32'h0, 32'h0);
        chk("t1_busy", busy, 1, 0);
        chk("t1_in_ready_run", in_ready, 0, 0);
        in_valid = 1'b1; mode = 1'b1; x_in = 32'h7FFFFFFF; y_in = 32'h80000000; z_in = 32'h12345678;
        wait_done("t1");
        in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0; mode = 1'b0;
        chk("t1_x", x_out, 32'h0D2C9082, TOL);
        chk("t1_y", y_out, 32'h00000000, TOL);
        chk("t1_z", z_out, 32'h00000000, TOL);
        hold_x = x_out;
        handshake("t1");

        // Test 2: rotate K by pi/4; previous result must persist during RUN
        launch("t2", 1'b0, K_CONST, 32'h0, 32'h0C90FDAA);
        chk("t2_hold_prev_x", x_out, hold_x, 0);
        wait_done("t2");
        chk("t2_x", x_out, 32'h0B504F33, TOL);
        chk("t2_y", y_out, 32'h0B504F33, TOL);
        chk("t2_z", z_out, 32'h00000000, TOL);
        handshake("t2");

        // Test 3/4: vectoring of (1,1), then backpressure for 5 cycles
        launch("t3", 1'b1, 32'h10000000, 32'h10000000, 32'h0);
        wait_done("t3");
        chk("t3_x", x_out, 32'h25430D30, TOL);
        chk("t3_y", y_out, 32'h00000000, TOL);
        chk("t3_z", z_out, 32'h0C90FDAA, TOL);
        hold_x = x_out; hold_y = y_out; hold_z = z_out;
        in_valid = 1'b1; mode = 1'b0; x_in = 32'h01000000; y_in = 32'h02000000; z_in = 32'h03000000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_bp_out_valid", out_valid, 1, 0);
            chk("t4_bp_in_ready", in_ready, 0, 0);
            chk("t4_bp_x", x_out, hold_x, 0);
            chk("t4_bp_y", y_out, hold_y, 0);
            chk("t4_bp_z", z_out, hold_z, 0);
        end
        in_valid = 1'b0; x_in = '0; y_in = '0; z_in = '0;
        handshake("t4");

        // Test 5: reset during iteration 7 aborts the operation
        launch("t5", 1'b0, 32'h08000000, 32'h0, 32'h0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0, 0);
        chk("t5_x_zero", x_out, 0, 0);
        chk("t5_y_zero", y_out, 0, 0);
        chk("t5_z_zero", z_out, 0, 0);
        chk("t5_busy", busy, 0, 0);
        chk("t5_in_ready", in_ready, 1, 0);

        // Test 6: negative angle -pi/4
        launch("t6", 1'b0, K_CONST, 32'h0, 32'hF36F0256);
        wait_done("t6");
        chk("t6_x", x_out, 32'h0B504F33, TOL);
        chk("t6_y", y_out, 32'hF4AFB0CD, TOL);
        chk("t6_z", z_out, 32'h00000000, TOL);
        handshake("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
